// File: rtl/ex_pipe_if.sv
// Issue-side and writeback-side handshake bundle for the execute stage.
// The master drives operations and out_ready; the slave is the execute stage.
interface ex_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rd_addr;
  logic            in_rd_wen;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd_data;
  logic [4:0]      out_rd_addr;
  logic            out_rd_wen;
  logic            out_pc_wen;
  logic [XLEN-1:0] out_pc_data;

  modport master (
    output in_valid, in_op, in_a, in_b, in_imm, in_pc, in_rd_addr, in_rd_wen, out_ready,
    input  in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_wen, out_pc_wen, out_pc_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_imm, in_pc, in_rd_addr, in_rd_wen, out_ready,
    output in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_wen, out_pc_wen, out_pc_data
  );
endinterface

// File: rtl/ex_pipe.sv
// Execute stage: single-cycle ALU/branch ops, iterative radix-2 multiplier,
// and a one-entry result holding register with valid/ready back-pressure.
module ex_pipe #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  ex_pipe_if.slave io
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t            state_reg;
  logic [SHW-1:0]    cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   mcand_reg;
  logic              mul_hi_reg;
  logic [4:0]        mul_addr_reg;
  logic              mul_wen_reg;
  logic              out_valid_reg;
  logic              out_rd_wen_reg;
  logic              out_pc_wen_reg;
  logic [XLEN-1:0]   out_rd_data_reg;
  logic [XLEN-1:0]   out_pc_data_reg;
  logic [4:0]        out_rd_addr_reg;

  logic              accept;
  logic              is_mul;
  logic              is_illegal;
  logic              rd_wen_eff;
  logic              alu_pc_wen;
  logic [XLEN-1:0]   alu_rd;
  logic [XLEN-1:0]   alu_pc;
  logic [XLEN-1:0]   jalr_sum;
  logic [SHW-1:0]    shamt;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  // New work is taken when idle, or when the held result leaves this cycle.
  assign io.in_ready = !rst && !flush &&
                       ((state_reg == IDLE) || ((state_reg == HOLD) && io.out_ready));
  assign accept      = io.in_valid && io.in_ready;
  assign is_mul      = (io.in_op[3:1] == 3'b111);
  assign is_illegal  = is_mul && !MUL_EN;
  assign rd_wen_eff  = io.in_rd_wen && (io.in_rd_addr != 5'd0);
  assign shamt       = io.in_b[SHW-1:0];
  assign jalr_sum    = io.in_a + io.in_imm;

  // One shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right; the multiplier sits in the low half.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mcand_reg & {XLEN{acc_reg[0]}}};
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  assign io.out_valid   = out_valid_reg;
  assign io.out_rd_data = out_rd_data_reg;
  assign io.out_rd_addr = out_rd_addr_reg;
  assign io.out_rd_wen  = out_rd_wen_reg;
  assign io.out_pc_wen  = out_pc_wen_reg;
  assign io.out_pc_data = out_pc_data_reg;

  // Single-cycle result and redirect target for the presented operation.
  always_comb begin
    alu_rd     = '0;
    alu_pc     = '0;
    alu_pc_wen = 1'b0;
    case (io.in_op)
      4'd0:  alu_rd = io.in_a + io.in_b;
      4'd1:  alu_rd = io.in_a - io.in_b;
      4'd2:  alu_rd = io.in_a & io.in_b;
      4'd3:  alu_rd = io.in_a | io.in_b;
      4'd4:  alu_rd = io.in_a ^ io.in_b;
      4'd5:  alu_rd = io.in_a << shamt;
      4'd6:  alu_rd = io.in_a >> shamt;
      4'd7:  alu_rd = $signed(io.in_a) >>> shamt;
      4'd8:  alu_rd = {{(XLEN-1){1'b0}}, ($signed(io.in_a) < $signed(io.in_b))};
      4'd9:  alu_rd = {{(XLEN-1){1'b0}}, (io.in_a < io.in_b)};
      4'd10: alu_rd = io.in_imm;
      4'd11: alu_rd = io.in_pc + io.in_imm;
      4'd12: begin
        alu_rd     = io.in_pc + XLEN'(4);
        alu_pc     = io.in_pc + io.in_imm;
        alu_pc_wen = 1'b1;
      end
      4'd13: begin
        alu_rd     = io.in_pc + XLEN'(4);
        alu_pc     = {jalr_sum[XLEN-1:1], 1'b0};
        alu_pc_wen = 1'b1;
      end
      default: alu_rd = '0;  // multiply ops are produced by the MUL state; illegal ops give 0
    endcase
  end

  // Control FSM with registered result outputs; reset beats flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      acc_reg         <= '0;
      mcand_reg       <= '0;
      mul_hi_reg      <= 1'b0;
      mul_addr_reg    <= 5'd0;
      mul_wen_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_rd_wen_reg  <= 1'b0;
      out_pc_wen_reg  <= 1'b0;
      out_rd_data_reg <= '0;
      out_pc_data_reg <= '0;
      out_rd_addr_reg <= 5'd0;
    end else if (flush) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_rd_wen_reg <= 1'b0;
      out_pc_wen_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if ((state_reg == HOLD) && !io.out_ready) begin
            state_reg <= HOLD;  // consumer stalled: keep every output stable
          end else if (accept && is_mul && MUL_EN) begin
            state_reg      <= MUL;
            cnt_reg        <= '0;
            acc_reg        <= {{XLEN{1'b0}}, io.in_b};
            mcand_reg      <= io.in_a;
            mul_hi_reg     <= io.in_op[0];
            mul_addr_reg   <= io.in_rd_addr;
            mul_wen_reg    <= rd_wen_eff;
            out_valid_reg  <= 1'b0;
            out_rd_wen_reg <= 1'b0;
            out_pc_wen_reg <= 1'b0;
          end else if (accept) begin
            state_reg       <= HOLD;
            out_valid_reg   <= 1'b1;
            out_rd_data_reg <= alu_rd;
            out_rd_addr_reg <= io.in_rd_addr;
            out_rd_wen_reg  <= rd_wen_eff && !is_illegal;
            out_pc_wen_reg  <= alu_pc_wen;
            out_pc_data_reg <= alu_pc;
          end else begin
            state_reg      <= IDLE;
            out_valid_reg  <= 1'b0;
            out_rd_wen_reg <= 1'b0;
            out_pc_wen_reg <= 1'b0;
          end
        end
        MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == SHW'(XLEN-1)) begin
            state_reg       <= HOLD;
            cnt_reg         <= '0;
            out_valid_reg   <= 1'b1;
            out_rd_data_reg <= mul_hi_reg ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
            out_rd_addr_reg <= mul_addr_reg;
            out_rd_wen_reg  <= mul_wen_reg;
            out_pc_wen_reg  <= 1'b0;
            out_pc_data_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_pipe.sv
// Randomized and directed checks of ex_pipe against a behavioural model of the op table.
module tb_ex_pipe;
  logic clk;
  logic rst;
  logic flush;
  int   vectors;
  int   miscompares;

  ex_pipe_if #(.XLEN(32)) bus ();
  ex_pipe_if #(.XLEN(32)) bus0 ();

  ex_pipe #(.XLEN(32), .MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .flush(flush), .io(bus));
  ex_pipe #(.XLEN(32), .MUL_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .flush(flush), .io(bus0));

  typedef struct packed {
    logic [31:0] rd;
    logic        rd_wen;
    logic        pc_wen;
    logic [31:0] pc;
  } exp_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: results straight from the op table, multiply via a native 64-bit product.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] addr, input logic wen);
    exp_t e;
    logic [63:0] prod;
    logic [31:0] t;
    prod     = {32'd0, a} * {32'd0, b};
    e.rd     = 32'd0;
    e.pc_wen = 1'b0;
    e.pc     = 32'd0;
    e.rd_wen = wen && (addr != 5'd0);
    case (op)
      4'd0:  e.rd = a + b;
      4'd1:  e.rd = a - b;
      4'd2:  e.rd = a & b;
      4'd3:  e.rd = a | b;
      4'd4:  e.rd = a ^ b;
      4'd5:  e.rd = a << b[4:0];
      4'd6:  e.rd = a >> b[4:0];
      4'd7:  e.rd = 32'($signed(a) >>> b[4:0]);
      4'd8:  e.rd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  e.rd = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.rd = imm;
      4'd11: e.rd = pc + imm;
      4'd12: begin e.rd = pc + 32'd4; e.pc_wen = 1'b1; e.pc = pc + imm; end
      4'd13: begin e.rd = pc + 32'd4; e.pc_wen = 1'b1; t = a + imm; e.pc = t & 32'hFFFF_FFFE; end
      4'd14: e.rd = prod[31:0];
      default: e.rd = prod[63:32];
    endcase
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] addr, input logic wen);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_imm     = imm;
    bus.in_pc      = pc;
    bus.in_rd_addr = addr;
    bus.in_rd_wen  = wen;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_op = 4'd0; bus0.in_a = 32'd0; bus0.in_b = 32'd0;
    bus0.in_imm = 32'd0; bus0.in_pc = 32'd0; bus0.in_rd_addr = 5'd0; bus0.in_rd_wen = 1'b0;
    bus0.out_ready = 1'b1;
    tick; tick;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    vectors++;
    if ({bus.out_valid, bus.out_rd_wen, bus.out_pc_wen, bus.out_rd_data, bus.out_rd_addr, bus.out_pc_data} !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b rw=%b pw=%b rd=%h a=%0d pc=%h expected all 0",
               bus.out_valid, bus.out_rd_wen, bus.out_pc_wen, bus.out_rd_data, bus.out_rd_addr, bus.out_pc_data);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add;
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL add_in_ready: got %b expected 1", bus.in_ready);
    end
    tick;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_rd_data, bus.out_rd_addr, bus.out_rd_wen, bus.out_pc_wen} !== {1'b1, 32'h0, 5'd5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL add_result: got v=%b rd=%h a=%0d rw=%b pw=%b expected v=1 rd=00000000 a=5 rw=1 pw=0",
               bus.out_valid, bus.out_rd_data, bus.out_rd_addr, bus.out_rd_wen, bus.out_pc_wen);
    end
    tick;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_rd_wen !== 1'b0) begin
      miscompares++; $display("FAIL add_drain: got v=%b rw=%b expected 0 0", bus.out_valid, bus.out_rd_wen);
    end
  endtask

  task automatic test_jalr;
    drive(4'd13, 32'h2003, $urandom, 32'd0, 32'h100, 5'd1, 1'b1);
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_rd_data, bus.out_pc_wen, bus.out_pc_data} !== {1'b1, 32'h104, 1'b1, 32'h2002}) begin
      miscompares++;
      $display("FAIL jalr: got v=%b rd=%h pw=%b pc=%h expected v=1 rd=00000104 pw=1 pc=00002002",
               bus.out_valid, bus.out_rd_data, bus.out_pc_wen, bus.out_pc_data);
    end
    tick;
    vectors++;
    if (bus.out_pc_wen !== 1'b0) begin
      miscompares++; $display("FAIL jalr_pc_wen_drop: got %b expected 0", bus.out_pc_wen);
    end
  endtask

  task automatic test_mulhu;
    int cyc;
    bit stall_bad;
    drive(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd7, 1'b1);
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    cyc = 1;
    stall_bad = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      if (bus.in_ready !== 1'b0 || bus.out_rd_wen !== 1'b0 || bus.out_pc_wen !== 1'b0) stall_bad = 1'b1;
      tick;
      cyc++;
    end
    vectors++;
    if (cyc != 33) begin
      miscompares++; $display("FAIL mulhu_latency: got %0d cycles expected 33", cyc);
    end
    vectors++;
    if (stall_bad) begin
      miscompares++; $display("FAIL mulhu_busy: in_ready/wen seen 1 during MUL, expected 0");
    end
    vectors++;
    if ({bus.out_rd_data, bus.out_rd_addr, bus.out_rd_wen} !== {32'hFFFF_FFFE, 5'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL mulhu_result: got rd=%h a=%0d rw=%b expected rd=fffffffe a=7 rw=1",
               bus.out_rd_data, bus.out_rd_addr, bus.out_rd_wen);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [31:0] qa[$];
    logic [31:0] a, b, sub_exp;
    a = $urandom; b = $urandom;
    sub_exp = a - b;
    drive(4'd1, a, b, 32'd0, 32'd0, 5'd3, 1'b1);
    bus.out_ready = 1'b0;
    tick;
    a = $urandom; b = $urandom;
    drive(4'd0, a, b, 32'd0, 32'd0, 5'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_rd_data !== sub_exp || bus.out_rd_addr !== 5'd3) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b rd=%h a=%0d expected rdy=0 v=1 rd=%h a=3",
                 i, bus.in_ready, bus.out_valid, bus.out_rd_data, bus.out_rd_addr, sub_exp);
      end
      tick;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = model(4'd0, a, b, 32'd0, 32'd0, 5'd4, 1'b1);
      qa.push_back(e.rd);
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.in_ready);
      end
      tick;
      a = $urandom; b = $urandom;
      bus.in_a = a; bus.in_b = b;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_rd_data !== qa[0]) begin
        miscompares++;
        $display("FAIL stream_result[%0d]: got v=%b rd=%h expected v=1 rd=%h", i, bus.out_valid, bus.out_rd_data, qa[0]);
      end
      void'(qa.pop_front());
    end
    bus.in_valid = 1'b0;
    tick;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL stream_drain: got v=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush;
    bit seen;
    logic [31:0] a, b;
    drive(4'd14, $urandom, $urandom, 32'd0, 32'd0, 5'd2, 1'b1);
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick;
    flush = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
    end
    tick;
    flush = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_idle: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL flush_no_result: got out_valid=1 after flush expected 0");
    end
    a = $urandom; b = $urandom;
    drive(4'd0, a, b, 32'd0, 32'd0, 5'd6, 1'b1);
    tick;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rd_data !== a + b) begin
      miscompares++; $display("FAIL flush_then_add: got v=%b rd=%h expected v=1 rd=%h", bus.out_valid, bus.out_rd_data, a + b);
    end
    tick;
  endtask

  task automatic test_reset_and_x0;
    bit seen;
    drive(4'd12, 32'd0, 32'd0, 32'h20, 32'h40, 5'd9, 1'b1);
    bus.out_ready = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc_wen !== 1'b1 || bus.out_pc_data !== 32'h60) begin
      miscompares++; $display("FAIL jal_hold: got v=%b pw=%b pc=%h expected v=1 pw=1 pc=00000060",
                              bus.out_valid, bus.out_pc_wen, bus.out_pc_data);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready);
    end
    tick;
    rst = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_rd_wen, bus.out_pc_wen, bus.out_rd_data, bus.out_rd_addr, bus.out_pc_data} !== 72'd0) begin
      miscompares++;
      $display("FAIL rst_in_hold: got v=%b rw=%b pw=%b rd=%h a=%0d pc=%h expected all 0",
               bus.out_valid, bus.out_rd_wen, bus.out_pc_wen, bus.out_rd_data, bus.out_rd_addr, bus.out_pc_data);
    end
    drive(4'd14, $urandom, $urandom, 32'd0, 32'd0, 5'd8, 1'b1);
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_mul_ready: got %b expected 1", bus.in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL rst_mid_mul_result: got out_valid=1 expected 0");
    end
    drive(4'd0, $urandom, $urandom, 32'd0, 32'd0, 5'd0, 1'b1);
    tick;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rd_wen !== 1'b0 || bus.out_rd_addr !== 5'd0) begin
      miscompares++; $display("FAIL x0_wen: got v=%b rw=%b a=%0d expected v=1 rw=0 a=0",
                              bus.out_valid, bus.out_rd_wen, bus.out_rd_addr);
    end
    tick;
  endtask

  task automatic test_illegal;
    for (int k = 14; k <= 15; k++) begin
      bus0.in_op = 4'(k); bus0.in_a = $urandom | 32'h1; bus0.in_b = $urandom | 32'h1;
      bus0.in_imm = $urandom; bus0.in_pc = $urandom;
      bus0.in_rd_addr = 5'd3; bus0.in_rd_wen = 1'b1; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
      tick;
      bus0.in_valid = 1'b0;
      vectors++;
      if ({bus0.out_valid, bus0.out_rd_data, bus0.out_rd_wen, bus0.out_pc_wen} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL illegal_op%0d: got v=%b rd=%h rw=%b pw=%b expected v=1 rd=00000000 rw=0 pw=0",
                 k, bus0.out_valid, bus0.out_rd_data, bus0.out_rd_wen, bus0.out_pc_wen);
      end
      tick;
    end
  endtask

  task automatic test_random;
    exp_t e;
    logic [3:0]  op;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  addr;
    logic        wen;
    int cyc, exp_lat, hold;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; imm = $urandom; pc = $urandom;
      addr = 5'($urandom_range(0, 31)); wen = 1'($urandom_range(0, 1));
      e = model(op, a, b, imm, pc, addr, wen);
      exp_lat = (op >= 4'd14) ? 33 : 1;
      drive(op, a, b, imm, pc, addr, wen);
      bus.out_ready = 1'b0;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL rand_ready n=%0d: got %b expected 1", n, bus.in_ready);
      end
      tick;
      bus.in_valid = 1'b0;
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
        tick;
        cyc++;
      end
      vectors++;
      if (cyc != exp_lat) begin
        miscompares++; $display("FAIL rand_latency n=%0d op=%0d: got %0d expected %0d", n, op, cyc, exp_lat);
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) tick;
      vectors++;
      if ({bus.out_rd_data, bus.out_rd_addr, bus.out_rd_wen, bus.out_pc_wen} !== {e.rd, addr, e.rd_wen, e.pc_wen}) begin
        miscompares++;
        $display("FAIL rand_result n=%0d op=%0d: got rd=%h a=%0d rw=%b pw=%b expected rd=%h a=%0d rw=%b pw=%b",
                 n, op, bus.out_rd_data, bus.out_rd_addr, bus.out_rd_wen, bus.out_pc_wen, e.rd, addr, e.rd_wen, e.pc_wen);
      end
      if (e.pc_wen) begin
        vectors++;
        if (bus.out_pc_data !== e.pc) begin
          miscompares++; $display("FAIL rand_pc n=%0d op=%0d: got %h expected %h", n, op, bus.out_pc_data, e.pc);
        end
      end
      bus.out_ready = 1'b1;
      tick;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.out_rd_wen !== 1'b0 || bus.out_pc_wen !== 1'b0) begin
        miscompares++; $display("FAIL rand_drain n=%0d: got v=%b rw=%b pw=%b expected 0 0 0",
                                n, bus.out_valid, bus.out_rd_wen, bus.out_pc_wen);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_add;
    test_jalr;
    test_mulhu;
    test_back_to_back;
    test_flush;
    test_reset_and_x0;
    test_illegal;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 Parameter XLEN, default 32, is the datapath width in bits (legal values 32 or 64).
REQ-002 Parameter MUL_EN, default 1: when 1, the multiply ops are implemented; when 0, they take the illegal-op path.
REQ-003 clk  input  1  is the single clock; every register updates on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 flush  input  1  synchronously discards any in-flight and held operation.
REQ-006 in_valid  input  1  means the issue stage presents an operation.
REQ-007 in_ready  output  1  means ex_pipe accepts the operation this cycle.
REQ-008 in_op  input  4  is the operation code (REQ-015).
REQ-009 in_a, in_b, in_imm, in_pc  input  XLEN each  carry operand A, operand B, the immediate and the instruction PC.
REQ-010 in_rd_addr  input  5  is the destination register; in_rd_wen  input  1  is the writeback request.
REQ-011 out_valid  input/output handshake: out_valid  output  1  means a result is held; out_ready  input  1  means the consumer takes it.
REQ-012 out_rd_data  output  XLEN, out_rd_addr  output  5 and out_rd_wen  output  1 are the writeback triple.
REQ-013 out_pc_wen  output  1 and out_pc_data  output  XLEN are the PC redirect.

Function
REQ-014 An operation is accepted on any cycle where in_valid and in_ready are both 1; all in_* values are captured on that edge.
REQ-015 Op codes and results (rd = out_rd_data):
- 0 ADD: a+b
- 1 SUB: a-b
- 2 AND, 3 OR, 4 XOR: bitwise on a, b
- 5 SLL, 6 SRL, 7 SRA: shift a by b[log2(XLEN)-1:0]
- 8 SLT (signed) and 9 SLTU (unsigned): {0...,a<b}
- 10 LUI: rd=imm
- 11 AUIPC: rd=pc+imm
- 12 JAL: rd=pc+4; redirect to pc+imm
- 13 JALR: rd=pc+4; redirect to (a+imm) with bit0 cleared
- 14 MUL: low XLEN bits of a*b
- 15 MULHU: high XLEN bits of the unsigned product a*b
REQ-016 All arithmetic is modulo 2^XLEN; carries out are discarded.
REQ-017 An illegal op (14/15 with MUL_EN=0) produces rd=0, out_rd_wen=0 and out_pc_wen=0, and still completes with latency 1.
REQ-018 FSM states are IDLE, MUL and HOLD.
- IDLE accepts operations.
- MUL iterates the multiply.
- HOLD presents a result.
REQ-019 in_ready = 1 only in IDLE, or in HOLD while out_ready=1 (back-to-back issue).
REQ-020 Transitions:
- Accept of ops 0-13 or an illegal op -> HOLD on the next edge (latency 1).
- Accept of op 14/15 with MUL_EN=1 -> MUL.
REQ-021 MUL is a radix-2 shift-add unit:
- exactly XLEN cycles in MUL, then HOLD;
- out_valid rises XLEN+1 cycles after accept.
REQ-022 In HOLD, out_valid=1 and all out_* stay stable until out_ready=1.
REQ-023 On the edge where out_ready=1 in HOLD, the state goes to HOLD if a new op is accepted that cycle, otherwise to IDLE.
REQ-024 out_rd_wen = captured in_rd_wen AND (in_rd_addr != 0) for ops 0-15; it is forced 0 for illegal ops.
REQ-025 out_rd_addr passes in_rd_addr through unchanged.
REQ-026 out_pc_wen=1 only for ops 12/13 and only while out_valid=1.
REQ-027 Whenever out_valid=0, out_pc_wen=0 and out_rd_wen=0.
REQ-028 flush=1 forces IDLE on the next edge and clears out_valid and the multiplier counter.
REQ-029 flush has priority over accept and over out_ready, and in_ready=0 while flush=1.
REQ-030 A flush during MUL abandons the product; no partial result is ever output.

Reset
REQ-031 When rst=1 at a clock edge:
- state goes to IDLE;
- out_valid, out_rd_wen and out_pc_wen go to 0;
- out_rd_data, out_pc_data and out_rd_addr go to 0;
- the multiply counter and accumulator go to 0.
REQ-032 rst overrides flush and all handshakes.
REQ-033 in_ready=0 during any cycle with rst=1 and is 1 on the first cycle after reset is released.
REQ-034 Reset asserted mid-MUL discards the operation.

Verification
REQ-035 ADD latency: op=0, a=0xFFFFFFFF, b=1, rd_addr=5, wen=1, out_ready=1 -> next cycle out_valid=1, rd=0x00000000, out_rd_addr=5, out_rd_wen=1, out_pc_wen=0.
REQ-036 JALR: op=13, pc=0x100, a=0x2003, imm=0 -> rd=0x104, out_pc_wen=1, out_pc_data=0x2002.
REQ-037 Multiply latency: op=15 (MULHU), a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, rd=0xFFFFFFFE, with in_ready=0 throughout MUL.
REQ-038 Back-pressure: out_ready=0 for 4 cycles after a SUB result appears -> out_* stable and in_ready=0 during those cycles; streaming ADDs with out_ready=1 -> one result per cycle.
REQ-039 Flush: flush at cycle 10 of a MUL -> IDLE on the next cycle, out_valid never rises, and a following ADD completes normally.
REQ-040 Reset and x0: rst=1 while in HOLD -> all outputs 0 on the next edge; rd_addr=0 with wen=1 -> out_rd_wen=0.
